// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, control bundle layout, and
// the small enums used by the ID/EX stage and its operand forwarding.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CTRL_W = 8;

    // Bit offsets of the fields packed into the EX/MEM control bundle
    localparam int unsigned CTRL_ALUOP_LSB = 0;
    localparam int unsigned CTRL_ALUOP_W   = 3;
    localparam int unsigned CTRL_ALUSRC    = 3;
    localparam int unsigned CTRL_MEMWR     = 4;
    localparam int unsigned CTRL_MEMRD     = 5;
    localparam int unsigned CTRL_BRANCH    = 6;

    // Control value carried by a bubble: no ALU op, no memory access, no branch
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    // Occupancy of the EX slot; the only state machine in the stage
    typedef enum logic {
        SLOT_BUBBLE = 1'b0,
        SLOT_VALID  = 1'b1
    } slot_e;

    // Operand source chosen by the forwarding network
    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Forwarding select for one ALU operand: EX/MEM result beats MEM/WB data,
// which beats the latched register-file value. Register 0 never forwards.
module fwd_mux #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] Src,
    input  logic [DATA_W-1:0] RegVal,
    input  logic [REG_AW-1:0] ExMemRW,
    input  logic              ExMemRegWr,
    input  logic [DATA_W-1:0] ExMemResult,
    input  logic [REG_AW-1:0] MemWbRW,
    input  logic              MemWbRegWr,
    input  logic [DATA_W-1:0] MemWbData,
    output logic [DATA_W-1:0] Op
);
    import cpu_pkg::*;

    fwd_sel_e sel;

    // Pick the youngest in-flight producer of the source register
    always_comb begin
        sel = FWD_REG;
        if (ExMemRegWr && (ExMemRW != '0) && (ExMemRW == Src)) begin
            sel = FWD_EXMEM;
        end else if (MemWbRegWr && (MemWbRW != '0) && (MemWbRW == Src)) begin
            sel = FWD_MEMWB;
        end
    end

    // Route the selected source onto the operand
    always_comb begin
        Op = RegVal;
        case (sel)
            FWD_EXMEM: Op = ExMemResult;
            FWD_MEMWB: Op = MemWbData;
            default:   Op = RegVal;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard
// detection (stall + bubble), branch flush and a saturating stall counter.
module id_ex_stage #(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned REG_AW = cpu_pkg::REG_AW,
    parameter int unsigned CTRL_W = cpu_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] BusA,
    input  logic [DATA_W-1:0] BusB,
    input  logic [REG_AW-1:0] RA,
    input  logic [REG_AW-1:0] RB,
    input  logic [REG_AW-1:0] RdIn,
    input  logic [DATA_W-1:0] ImmIn,
    input  logic [CTRL_W-1:0] CtrlIn,
    input  logic              RegWrIn,
    input  logic              MemRdIn,
    input  logic              Flush,
    input  logic [REG_AW-1:0] ExMemRW,
    input  logic              ExMemRegWr,
    input  logic [DATA_W-1:0] ExMemResult,
    input  logic [REG_AW-1:0] MemWbRW,
    input  logic              MemWbRegWr,
    input  logic [DATA_W-1:0] MemWbData,
    output logic [DATA_W-1:0] OpA,
    output logic [DATA_W-1:0] OpB,
    output logic [DATA_W-1:0] ImmOut,
    output logic [REG_AW-1:0] RdOut,
    output logic [CTRL_W-1:0] CtrlOut,
    output logic              RegWrOut,
    output logic              MemRdOut,
    output logic              Valid,
    output logic              Stall,
    output logic [CNT_W-1:0]  StallCount
);
    import cpu_pkg::*;

    slot_e             slot_q,  slot_d;
    logic [REG_AW-1:0] ra_q,    ra_d;
    logic [REG_AW-1:0] rb_q,    rb_d;
    logic [DATA_W-1:0] busa_q,  busa_d;
    logic [DATA_W-1:0] busb_q,  busb_d;
    logic [DATA_W-1:0] imm_q,   imm_d;
    logic [REG_AW-1:0] rd_q,    rd_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic              regwr_q, regwr_d;
    logic              memrd_q, memrd_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              stall;

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        stall = (slot_q == SLOT_VALID) && memrd_q && regwr_q && (rd_q != '0)
                && ((rd_q == RA) || (rd_q == RB));
    end

    // Next-state: reset, bubble on flush/stall (data held), else capture ID
    always_comb begin
        slot_d  = slot_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        busa_d  = busa_q;
        busb_d  = busb_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        regwr_d = regwr_q;
        memrd_d = memrd_q;
        cnt_d   = cnt_q;
        if (Rst) begin
            slot_d  = SLOT_BUBBLE;
            ra_d    = '0;
            rb_d    = '0;
            busa_d  = '0;
            busb_d  = '0;
            imm_d   = '0;
            rd_d    = '0;
            ctrl_d  = '0;
            regwr_d = 1'b0;
            memrd_d = 1'b0;
            cnt_d   = '0;
        end else begin
            if (stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (Flush || stall) begin
                slot_d  = SLOT_BUBBLE;
                regwr_d = 1'b0;
                memrd_d = 1'b0;
                ctrl_d  = CTRL_W'(CTRL_NOP);
            end else begin
                slot_d  = SLOT_VALID;
                ra_d    = RA;
                rb_d    = RB;
                busa_d  = BusA;
                busb_d  = BusB;
                imm_d   = ImmIn;
                rd_d    = RdIn;
                ctrl_d  = CtrlIn;
                regwr_d = RegWrIn;
                memrd_d = MemRdIn;
            end
        end
    end

    // ID/EX register bank and stall counter
    always_ff @(posedge Clk) begin
        slot_q  <= slot_d;
        ra_q    <= ra_d;
        rb_q    <= rb_d;
        busa_q  <= busa_d;
        busb_q  <= busb_d;
        imm_q   <= imm_d;
        rd_q    <= rd_d;
        ctrl_q  <= ctrl_d;
        regwr_q <= regwr_d;
        memrd_q <= memrd_d;
        cnt_q   <= cnt_d;
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .Src         (ra_q),
        .RegVal      (busa_q),
        .ExMemRW     (ExMemRW),
        .ExMemRegWr  (ExMemRegWr),
        .ExMemResult (ExMemResult),
        .MemWbRW     (MemWbRW),
        .MemWbRegWr  (MemWbRegWr),
        .MemWbData   (MemWbData),
        .Op          (OpA)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .Src         (rb_q),
        .RegVal      (busb_q),
        .ExMemRW     (ExMemRW),
        .ExMemRegWr  (ExMemRegWr),
        .ExMemResult (ExMemResult),
        .MemWbRW     (MemWbRW),
        .MemWbRegWr  (MemWbRegWr),
        .MemWbData   (MemWbData),
        .Op          (OpB)
    );

    assign ImmOut     = imm_q;
    assign RdOut      = rd_q;
    assign CtrlOut    = ctrl_q;
    assign RegWrOut   = regwr_q;
    assign MemRdOut   = memrd_q;
    assign Valid      = (slot_q == SLOT_VALID);
    assign Stall      = stall;
    assign StallCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. The stall counter is narrowed to 4 bits
// so saturation is reachable in a short run.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;
    localparam int NW = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [DW-1:0] BusA, BusB, ImmIn, ExMemResult, MemWbData;
    logic [AW-1:0] RA, RB, RdIn, ExMemRW, MemWbRW;
    logic [CW-1:0] CtrlIn;
    logic          RegWrIn, MemRdIn, Flush, ExMemRegWr, MemWbRegWr;
    logic [DW-1:0] OpA, OpB, ImmOut;
    logic [AW-1:0] RdOut;
    logic [CW-1:0] CtrlOut;
    logic          RegWrOut, MemRdOut, Valid, Stall;
    logic [NW-1:0] StallCount;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .Clk(Clk), .Rst(Rst), .BusA(BusA), .BusB(BusB), .RA(RA), .RB(RB),
        .RdIn(RdIn), .ImmIn(ImmIn), .CtrlIn(CtrlIn), .RegWrIn(RegWrIn),
        .MemRdIn(MemRdIn), .Flush(Flush), .ExMemRW(ExMemRW),
        .ExMemRegWr(ExMemRegWr), .ExMemResult(ExMemResult), .MemWbRW(MemWbRW),
        .MemWbRegWr(MemWbRegWr), .MemWbData(MemWbData), .OpA(OpA), .OpB(OpB),
        .ImmOut(ImmOut), .RdOut(RdOut), .CtrlOut(CtrlOut), .RegWrOut(RegWrOut),
        .MemRdOut(MemRdOut), .Valid(Valid), .Stall(Stall), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          valid, regwr, memrd;
        logic [AW-1:0] rd, ra, rb;
        logic [DW-1:0] a, b, imm;
        logic [CW-1:0] ctrl;
        logic [NW-1:0] cnt;
    } exp_t;

    exp_t q[$];

    // Reference state of the EX slot
    logic          m_known = 1'b0;
    logic          m_valid = 1'b0, m_regwr = 1'b0, m_memrd = 1'b0;
    logic [AW-1:0] m_rd = '0, m_ra = '0, m_rb = '0;
    logic [DW-1:0] m_a = '0, m_b = '0, m_imm = '0;
    logic [CW-1:0] m_ctrl = '0;
    logic [NW-1:0] m_cnt = '0;

    function automatic logic model_stall(input logic v, input logic mr, input logic rw,
                                         input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                                         input logic [AW-1:0] rb);
        return v && mr && rw && (rd != 0) && ((rd == ra) || (rd == rb));
    endfunction

    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] src, input logic [DW-1:0] regval);
        if (ExMemRegWr && ExMemRW != 0 && ExMemRW == src) return ExMemResult;
        if (MemWbRegWr && MemWbRW != 0 && MemWbRW == src) return MemWbData;
        return regval;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ops(input string tag);
        #1;
        check({tag, ".opa"}, OpA, fwd(m_ra, m_a));
        check({tag, ".opb"}, OpB, fwd(m_rb, m_b));
    endtask

    task automatic id(input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [AW-1:0] rd,
                      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] imm,
                      input logic [CW-1:0] ctrl, input logic regwr, input logic memrd);
        RA = ra; RB = rb; RdIn = rd; BusA = a; BusB = b; ImmIn = imm;
        CtrlIn = ctrl; RegWrIn = regwr; MemRdIn = memrd;
    endtask

    // One clock: check Stall, predict the EX slot, clock, compare against the popped prediction
    task automatic step(input string tag);
        logic s;
        exp_t e, g;
        #1;
        s = model_stall(m_valid, m_memrd, m_regwr, m_rd, RA, RB);
        if (m_known) check({tag, ".stall"}, Stall, s);
        if (Rst) begin
            m_valid = 0; m_regwr = 0; m_memrd = 0; m_rd = 0; m_ra = 0; m_rb = 0;
            m_a = 0; m_b = 0; m_imm = 0; m_ctrl = 0; m_cnt = 0; m_known = 1;
        end else begin
            if (s && m_cnt != {NW{1'b1}}) m_cnt = m_cnt + 1;
            if (Flush || s) begin
                m_valid = 0; m_regwr = 0; m_memrd = 0; m_ctrl = 0;
            end else begin
                m_valid = 1; m_regwr = RegWrIn; m_memrd = MemRdIn; m_rd = RdIn;
                m_ra = RA; m_rb = RB; m_a = BusA; m_b = BusB; m_imm = ImmIn; m_ctrl = CtrlIn;
            end
        end
        e.valid = m_valid; e.regwr = m_regwr; e.memrd = m_memrd; e.rd = m_rd;
        e.ra = m_ra; e.rb = m_rb; e.a = m_a; e.b = m_b; e.imm = m_imm;
        e.ctrl = m_ctrl; e.cnt = m_cnt;
        q.push_back(e);
        @(posedge Clk);
        #1;
        g = q.pop_front();
        check({tag, ".valid"}, Valid, g.valid);
        check({tag, ".regwr"}, RegWrOut, g.regwr);
        check({tag, ".memrd"}, MemRdOut, g.memrd);
        check({tag, ".ctrl"}, CtrlOut, g.ctrl);
        check({tag, ".cnt"}, StallCount, g.cnt);
        if (g.valid) begin
            check({tag, ".rd"}, RdOut, g.rd);
            check({tag, ".imm"}, ImmOut, g.imm);
            check({tag, ".opa"}, OpA, fwd(g.ra, g.a));
            check({tag, ".opb"}, OpB, fwd(g.rb, g.b));
        end
    endtask

    task automatic clear_bypass();
        ExMemRW = 0; ExMemRegWr = 0; ExMemResult = 0;
        MemWbRW = 0; MemWbRegWr = 0; MemWbData = 0;
    endtask

    initial begin
        Rst = 1; Flush = 0;
        clear_bypass();
        id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge Clk);
        #1;
        step("rst0");
        step("rst1");
        check("rst.opa", OpA, 32'h0);
        check("rst.rd", RdOut, 32'h0);
        check("rst.stall", Stall, 32'h0);
        Rst = 0;

        // Basic capture
        id(1, 2, 3, 32'h11, 32'h22, 32'h100, 8'h03, 1, 0);
        step("cap");
        check("cap.opa_abs", OpA, 32'h11);
        check("cap.opb_abs", OpB, 32'h22);

        // Load-use stall, then re-capture of the held instruction
        id(0, 0, 5, 32'h0, 32'h0, 32'h4, 8'h21, 1, 1);
        step("ld");
        id(5, 6, 7, 32'h55, 32'h66, 32'h8, 8'h01, 1, 0);
        step("use_stall");
        check("use.cnt_abs", StallCount, 32'h1);
        step("use_recap");
        check("recap.opa_abs", OpA, 32'h55);

        // Forwarding priority on RAq = 7, RBq = 8
        id(7, 8, 9, 32'h70, 32'h80, 32'h0, 8'h02, 1, 0);
        step("fwd");
        ExMemRW = 7; ExMemRegWr = 1; ExMemResult = 32'hAAAA;
        MemWbRW = 7; MemWbRegWr = 1; MemWbData = 32'hBBBB;
        check_ops("fwd_both");
        check("fwd.exmem_abs", OpA, 32'hAAAA);
        ExMemRegWr = 0;
        check_ops("fwd_wb");
        check("fwd.memwb_abs", OpA, 32'hBBBB);
        MemWbRegWr = 0;
        check_ops("fwd_none");
        MemWbRW = 8; MemWbRegWr = 1; MemWbData = 32'hCCCC;
        check_ops("fwd_b");
        check("fwd.b_abs", OpB, 32'hCCCC);
        clear_bypass();

        // Register 0 is never forwarded and never causes a stall
        id(0, 0, 1, 32'h0, 32'h0, 32'h0, 8'h00, 1, 0);
        step("r0");
        ExMemRW = 0; ExMemRegWr = 1; ExMemResult = 32'hFFFF;
        check_ops("r0_fwd");
        check("r0.opa_abs", OpA, 32'h0);
        clear_bypass();
        id(0, 0, 0, 32'h0, 32'h0, 32'h0, 8'h21, 1, 1);
        step("r0_ld");
        id(0, 0, 2, 32'h0, 32'h0, 32'h0, 8'h01, 1, 0);
        step("r0_use");

        // Flush coinciding with a load-use stall: one bubble, one count
        id(1, 1, 4, 32'h1, 32'h1, 32'h0, 8'h21, 1, 1);
        step("fl_ld");
        id(4, 3, 6, 32'h44, 32'h33, 32'h0, 8'h01, 1, 0);
        Flush = 1;
        step("fl_stall");
        check("fl.cnt_abs", StallCount, 32'h2);
        Flush = 0;
        step("fl_recap");
        Flush = 1;
        id(2, 3, 6, 32'h9, 32'h9, 32'h9, 8'h05, 1, 0);
        step("flush_only");
        Flush = 0;

        // Drive the counter into saturation
        for (int i = 0; i < 16; i++) begin
            id(1, 1, 5, 32'h1, 32'h1, 32'h0, 8'h21, 1, 1);
            step("sat_ld");
            id(5, 0, 6, 32'h5, 32'h0, 32'h0, 8'h01, 1, 0);
            step("sat_use");
        end
        check("sat.cnt_abs", StallCount, 32'hF);

        // Reset with a valid load in EX and a stall pending
        id(1, 1, 5, 32'h1, 32'h1, 32'h0, 8'h21, 1, 1);
        step("mid_ld");
        id(5, 0, 6, 32'h5, 32'h0, 32'h0, 8'h01, 1, 0);
        #1;
        check("mid.stall_pre", Stall, 32'h1);
        Rst = 1;
        step("mid_rst");
        check("mid.stall_post", Stall, 32'h0);
        check("mid.opa", OpA, 32'h0);
        check("mid.rd", RdOut, 32'h0);
        check("mid.imm", ImmOut, 32'h0);
        Rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
